// File: rtl/im_ctrl_pkg.sv
// Shared types and constants for the Ising-machine run sequencer.
// Holds the state encoding and the zero-means-max/zero-means-one config mappings.
package im_ctrl_pkg;
  localparam int N_STEPS = 16;
  localparam int LEVEL_W = 8;
  localparam int CNT_W   = 8;
  localparam int TMR_W   = 9;

  localparam logic [TMR_W-1:0] INTERVAL_ZERO_VAL  = 9'd256;
  localparam logic [CNT_W-1:0] RUN_COUNT_ZERO_VAL = 8'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_LOADED, S_ANNEAL, S_SAMPLE, S_DONE
  } e_seq_state;

  function automatic logic [TMR_W-1:0] eff_interval(input logic [CNT_W-1:0] iv);
    return (iv == '0) ? INTERVAL_ZERO_VAL : {1'b0, iv};
  endfunction

  function automatic logic [CNT_W-1:0] eff_runs(input logic [CNT_W-1:0] rc);
    return (rc == '0) ? RUN_COUNT_ZERO_VAL : rc;
  endfunction
endpackage

// File: rtl/im_run_sequencer_timer.sv
// Loadable 9-bit down-counter; expire flags the last cycle of a loaded period.
// A reload in the expiring cycle starts the next period back to back.
module seq_interval_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [8:0] i_load_val,
  output logic       o_expire
);
  logic [8:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 9'd1;
  end

  assign o_expire = (r_cnt == 9'd1);
endmodule

// File: rtl/im_run_sequencer.sv
// Run sequencer: walks the core through init, load, anneal and sample phases
// driven by edges on the SPI control bits, repeating runs and bounded reruns.
module im_run_sequencer #(
  parameter int INIT_CYCLES = 4,
  parameter int N_STEPS     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ctrl_reset,
  input  logic                 i_ctrl_init,
  input  logic                 i_ctrl_load,
  input  logic                 i_ctrl_run,
  input  logic                 i_ctrl_rerun,
  input  logic [7:0]           i_run_time_interval,
  input  logic [7:0]           i_total_run_count,
  input  logic [7:0]           i_total_rerun_count,
  input  logic [N_STEPS*8-1:0] i_anneal_sch,
  input  logic                 i_load_ack,
  input  logic                 i_sample_ack,
  output logic                 o_core_init,
  output logic                 o_load_req,
  output logic                 o_spin_en,
  output logic [7:0]           o_anneal_level,
  output logic [3:0]           o_anneal_step,
  output logic                 o_sample_req,
  output logic [7:0]           o_run_idx,
  output logic [7:0]           o_rerun_idx,
  output logic                 o_loading_done,
  output logic                 o_running,
  output logic                 o_run_done
);
  import im_ctrl_pkg::*;

  e_seq_state  r_state;
  logic [4:0]  r_ctrl_q, r_ctrl_prev;  // {reset, init, load, run, rerun}
  logic        r_core_init, r_load_req, r_sample_req, r_loading_done;
  logic [7:0]  r_level, r_run_idx, r_rerun_idx;
  logic [3:0]  r_step;

  logic [4:0]  w_edge;
  logic        w_clr, w_init_e, w_load_e, w_run_e, w_rerun_e;
  logic        w_rerun_ok, w_last_step, w_more_runs, w_tmr_exp, w_tmr_load;
  logic [8:0]  w_tmr_val;
  logic [7:0]  w_eff_runs, w_run_inc, w_lvl0, w_lvl_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl_q    <= '0;
      r_ctrl_prev <= '0;
    end else begin
      r_ctrl_q    <= {i_ctrl_reset, i_ctrl_init, i_ctrl_load, i_ctrl_run, i_ctrl_rerun};
      r_ctrl_prev <= r_ctrl_q;
    end
  end

  // Only the highest-priority edge of a cycle survives.
  assign w_edge    = r_ctrl_q & ~r_ctrl_prev;
  assign w_clr     = i_rst | r_ctrl_q[4];
  assign w_init_e  = w_edge[3];
  assign w_load_e  = w_edge[2] & ~w_edge[3];
  assign w_run_e   = w_edge[1] & ~|w_edge[3:2];
  assign w_rerun_e = w_edge[0] & ~|w_edge[3:1];

  assign w_rerun_ok  = r_rerun_idx < i_total_rerun_count;
  assign w_last_step = (r_step == 4'(N_STEPS - 1));
  assign w_eff_runs  = eff_runs(i_total_run_count);
  assign w_more_runs = ({1'b0, r_run_idx} + 9'd1) < {1'b0, w_eff_runs};
  assign w_run_inc   = (({1'b0, r_run_idx} + 9'd1) > {1'b0, w_eff_runs}) ? w_eff_runs
                                                                         : r_run_idx + 8'd1;
  assign w_lvl0      = i_anneal_sch[N_STEPS*8-1 -: 8];
  assign w_lvl_next  = i_anneal_sch[N_STEPS*8-1 - 8*int'(r_step + 4'd1) -: 8];

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = eff_interval(i_run_time_interval);
    if (!w_clr) begin
      case (r_state)
        S_IDLE, S_LOADED, S_DONE: begin
          if (w_init_e) begin
            w_tmr_load = 1'b1;
            w_tmr_val  = 9'(INIT_CYCLES);
          end else if ((r_state == S_LOADED && w_run_e) ||
                       (r_state == S_DONE && w_rerun_e && w_rerun_ok)) begin
            w_tmr_load = 1'b1;
          end
        end
        S_ANNEAL: w_tmr_load = w_tmr_exp && !w_last_step;
        S_SAMPLE: w_tmr_load = i_sample_ack && w_more_runs;
        default:  w_tmr_load = 1'b0;
      endcase
    end
  end

  seq_interval_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (w_clr),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expire   (w_tmr_exp)
  );

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state        <= S_IDLE;
      r_core_init    <= 1'b0;
      r_load_req     <= 1'b0;
      r_sample_req   <= 1'b0;
      r_loading_done <= 1'b0;
      r_level        <= '0;
      r_step         <= '0;
      r_run_idx      <= '0;
      r_rerun_idx    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_LOADED, S_DONE: begin
          if (w_init_e) begin
            r_state        <= S_INIT;
            r_core_init    <= 1'b1;
            r_loading_done <= 1'b0;
            r_rerun_idx    <= '0;
          end else if (r_state == S_IDLE && w_load_e) begin
            r_state    <= S_LOAD;
            r_load_req <= 1'b1;
          end else if ((r_state == S_LOADED && w_run_e) ||
                       (r_state == S_DONE && w_rerun_e && w_rerun_ok)) begin
            if (r_state == S_DONE) r_rerun_idx <= r_rerun_idx + 8'd1;
            r_state   <= S_ANNEAL;
            r_run_idx <= '0;
            r_step    <= '0;
            r_level   <= w_lvl0;
          end
        end
        S_INIT: if (w_tmr_exp) begin
          r_state     <= S_IDLE;
          r_core_init <= 1'b0;
        end
        S_LOAD: if (i_load_ack) begin
          r_state        <= S_LOADED;
          r_load_req     <= 1'b0;
          r_loading_done <= 1'b1;
        end
        S_ANNEAL: if (w_tmr_exp) begin
          if (w_last_step) begin
            r_state      <= S_SAMPLE;
            r_sample_req <= 1'b1;
            r_step       <= '0;
            r_level      <= '0;
          end else begin
            r_step  <= r_step + 4'd1;
            r_level <= w_lvl_next;
          end
        end
        S_SAMPLE: if (i_sample_ack) begin
          r_sample_req <= 1'b0;
          r_run_idx    <= w_run_inc;
          if (w_more_runs) begin
            r_state <= S_ANNEAL;
            r_level <= w_lvl0;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_core_init    = r_core_init;
  assign o_load_req     = r_load_req;
  assign o_sample_req   = r_sample_req;
  assign o_spin_en      = (r_state == S_ANNEAL);
  assign o_running      = (r_state == S_ANNEAL) || (r_state == S_SAMPLE);
  assign o_run_done     = (r_state == S_DONE);
  assign o_anneal_level = r_level;
  assign o_anneal_step  = r_step;
  assign o_run_idx      = r_run_idx;
  assign o_rerun_idx    = r_rerun_idx;
  assign o_loading_done = r_loading_done;
endmodule

// File: tb/tb_im_run_sequencer.sv
// Scoreboard bench: stimulus pushes expected phase events, a monitor pops them
// as the sequencer produces init pulses, anneal steps, samples and completions.
module tb_im_run_sequencer;
  localparam int EV_INIT = 0, EV_LOADED = 1, EV_STEP = 2, EV_SAMPLE = 3,
                 EV_DONE = 4, EV_ABORT = 5;
  localparam logic [4:0] M_RST = 5'b10000, M_INIT = 5'b01000, M_LOAD = 5'b00100,
                         M_RUN = 5'b00010, M_RERUN = 5'b00001;

  typedef struct { int kind; int a; int b; int c; } ev_t;

  logic clk = 0, rst = 1;
  logic c_reset = 0, c_init = 0, c_load = 0, c_run = 0, c_rerun = 0;
  logic [7:0] iv = 0, runs = 0, rr_max = 0;
  logic [127:0] sch_bus = '0;
  logic load_ack = 0, sample_ack = 0;
  logic core_init, load_req, spin_en, sample_req, loading_done, running, run_done;
  logic [7:0] level, run_idx, rerun_idx;
  logic [3:0] step;

  int n_vec = 0, n_err = 0;
  ev_t exp_q[$];
  logic [7:0] sch [16];
  bit mon_en = 0, auto_ack = 1;
  int load_dly = 3;

  im_run_sequencer #(.INIT_CYCLES(4), .N_STEPS(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ctrl_reset(c_reset), .i_ctrl_init(c_init), .i_ctrl_load(c_load),
    .i_ctrl_run(c_run), .i_ctrl_rerun(c_rerun),
    .i_run_time_interval(iv), .i_total_run_count(runs), .i_total_rerun_count(rr_max),
    .i_anneal_sch(sch_bus), .i_load_ack(load_ack), .i_sample_ack(sample_ack),
    .o_core_init(core_init), .o_load_req(load_req), .o_spin_en(spin_en),
    .o_anneal_level(level), .o_anneal_step(step), .o_sample_req(sample_req),
    .o_run_idx(run_idx), .o_rerun_idx(rerun_idx), .o_loading_done(loading_done),
    .o_running(running), .o_run_done(run_done)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] all_outs();
    return {core_init, load_req, spin_en, level, step, sample_req,
            run_idx, rerun_idx, loading_done, running, run_done};
  endfunction

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic push(input int k, input int a, input int b, input int c);
    exp_q.push_back('{k, a, b, c});
  endtask

  task automatic check_ev(input int k, input int a, input int b, input int c);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got kind=%0d (%0d,%0d,%0d) required none", k, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
        n_err++;
        $display("FAIL event: got kind=%0d (%0d,%0d,%0d) required kind=%0d (%0d,%0d,%0d)",
                 k, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  // Reference: a batch is runs x 16 steps of I cycles each, a sample per run, then done.
  task automatic push_batch(input int iv_v, input int runs_v, input int rr_idx);
    int ei = (iv_v == 0) ? 256 : iv_v;
    int er = (runs_v == 0) ? 1 : runs_v;
    for (int r = 0; r < er; r++) begin
      for (int k = 0; k < 16; k++) push(EV_STEP, k, int'(sch[k]), ei);
      push(EV_SAMPLE, r, 0, 0);
    end
    push(EV_DONE, er, rr_idx, 0);
  endtask

  task automatic apply_sch();
    for (int k = 0; k < 16; k++) sch_bus[127 - 8*k -: 8] = sch[k];
  endtask

  task automatic pulse(input logic [4:0] m);
    @(posedge clk); #1;
    {c_reset, c_init, c_load, c_run, c_rerun} = m;
    repeat (2) @(posedge clk); #1;
    {c_reset, c_init, c_load, c_run, c_rerun} = '0;
  endtask

  task automatic drain(input int budget, input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_timeout: got %0d events pending required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_init();
    push(EV_INIT, 4, 0, 0);
    pulse(M_INIT);
    drain(20, "init");
  endtask

  task automatic do_load();
    push(EV_LOADED, 0, 0, 0);
    pulse(M_LOAD);
    drain(40, "load");
  endtask

  task automatic do_run(input int iv_v, input int runs_v, input int rr_idx);
    int ei = (iv_v == 0) ? 256 : iv_v;
    int er = (runs_v == 0) ? 1 : runs_v;
    iv = 8'(iv_v); runs = 8'(runs_v);
    push_batch(iv_v, runs_v, rr_idx);
    pulse(M_RUN);
    drain(er * (16*ei + 10) + 50, "run");
  endtask

  task automatic rerun_series(input int iv_v, input int runs_v, input int rmax);
    int ei = (iv_v == 0) ? 256 : iv_v;
    int er = (runs_v == 0) ? 1 : runs_v;
    iv = 8'(iv_v); runs = 8'(runs_v); rr_max = 8'(rmax);
    for (int j = 0; j <= rmax; j++) begin
      if (j < rmax) begin
        push_batch(iv_v, runs_v, j + 1);
        pulse(M_RERUN);
        drain(er * (16*ei + 10) + 50, "rerun");
      end else begin
        pulse(M_RERUN);
        repeat (8) @(negedge clk);
        chk("rerun_over_limit_done", run_done, 1);
        chk("rerun_idx_saturated", rerun_idx, rmax);
      end
    end
  endtask

  // Load engine responder.
  initial forever begin
    @(posedge clk); #1;
    if (auto_ack && load_req) begin
      repeat (load_dly) @(posedge clk);
      #1 load_ack = 1;
      @(posedge clk); #1 load_ack = 0;
    end
  end

  // Sampler responder.
  initial forever begin
    @(posedge clk); #1;
    if (auto_ack && sample_req) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 sample_ack = 1;
      @(posedge clk); #1 sample_ack = 0;
    end
  end

  // Monitor: turns output waveforms into events and checks them against the queue.
  int cur_step = 0, cur_lvl = 0, scnt = 0, icnt = 0;
  bit p_spin = 0, p_sreq = 0, p_init = 0, p_ld = 0, p_rd = 0;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (spin_en) begin
        if (p_spin && int'(step) == cur_step) scnt++;
        else begin
          if (p_spin) check_ev(EV_STEP, cur_step, cur_lvl, scnt);
          cur_step = int'(step); cur_lvl = int'(level); scnt = 1;
        end
      end else if (p_spin) begin
        if (sample_req) check_ev(EV_STEP, cur_step, cur_lvl, scnt);
        else            check_ev(EV_ABORT, cur_step, 0, 0);
      end
      if (sample_req && !p_sreq) check_ev(EV_SAMPLE, int'(run_idx), 0, 0);
      if (core_init) icnt++;
      else if (p_init) begin
        check_ev(EV_INIT, icnt, 0, 0);
        icnt = 0;
      end
      if (loading_done && !p_ld) check_ev(EV_LOADED, 0, 0, 0);
      if (run_done && !p_rd) check_ev(EV_DONE, int'(run_idx), int'(rerun_idx), 0);
      p_spin = spin_en; p_sreq = sample_req; p_init = core_init;
      p_ld = loading_done; p_rd = run_done;
    end
  end

  initial begin
    int n, lr;
    logic [34:0] z = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), z);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("post_reset_outputs", all_outs(), z);
    chk("post_reset_running", running, 0);
    mon_en = 1;

    // Illegal RUN from IDLE.
    pulse(M_RUN);
    repeat (5) @(negedge clk);
    chk("illegal_run_running", running, 0);
    chk("illegal_run_spin", spin_en, 0);

    // Normal run: ramp schedule, interval 2, one run.
    for (int k = 0; k < 16; k++) sch[k] = 8'(k);
    apply_sch();
    do_load();
    chk("normal_loading_done", loading_done, 1);
    do_run(2, 1, 0);
    chk("normal_run_done", run_done, 1);
    chk("normal_run_idx", run_idx, 1);

    // Repeated runs at the maximal interval.
    for (int k = 0; k < 16; k++) sch[k] = 8'($urandom);
    apply_sch();
    do_init();
    chk("init_clears_loading_done", loading_done, 0);
    do_load();
    do_run(0, 3, 0);
    chk("repeat_run_idx", run_idx, 3);

    // Rerun limit of one.
    rerun_series(1, 3, 1);

    // Randomized batches.
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 16; k++) sch[k] = 8'($urandom);
      apply_sch();
      load_dly = $urandom_range(0, 4);
      rr_max = 8'($urandom_range(0, 2));
      do_init();
      chk("rand_rerun_cleared", rerun_idx, 0);
      do_load();
      do_run($urandom_range(1, 6), $urandom_range(0, 3), 0);
      rerun_series(int'(iv), int'(runs), int'(rr_max));
    end

    // INIT and LOAD rising together from IDLE: only INIT is taken.
    do_init();
    push(EV_INIT, 4, 0, 0);
    lr = 0;
    fork
      pulse(M_INIT | M_LOAD);
      repeat (12) begin @(negedge clk); if (load_req) lr++; end
    join
    drain(20, "init_load");
    chk("init_load_no_load_req", lr, 0);
    chk("init_load_loading_done", loading_done, 0);

    // Soft reset in the middle of an anneal at step 5.
    do_load();
    auto_ack = 0;
    iv = 3; runs = 2;
    for (int k = 0; k < 5; k++) push(EV_STEP, k, int'(sch[k]), 3);
    push(EV_ABORT, 5, 0, 0);
    pulse(M_RUN);
    n = 0;
    while (!(spin_en && step == 4'd5) && n < 200) begin @(negedge clk); n++; end
    chk("reach_step5", step, 5);
    @(posedge clk); #1 c_reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("soft_reset_outputs", all_outs(), z);
    @(posedge clk); #1 c_reset = 0;
    @(posedge clk); #1 sample_ack = 1;
    @(posedge clk); #1 sample_ack = 0;
    repeat (4) @(negedge clk);
    chk("late_ack_ignored", all_outs(), z);
    drain(10, "soft_reset");
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
